// File: rtl/dec_pkg.sv
// Shared types and constants for the timed 2-to-4 decoder.
package dec_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

  localparam dec_state_e       STATE_RST = IDLE;
  localparam logic [3:0]       OUT_RST   = 4'b0000;
  localparam logic             DONE_RST  = 1'b0;
  localparam logic [CNT_W-1:0] CNT_RST   = '0;

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction
endpackage

// File: rtl/dec_hold_timer.sv
// Loadable down-counter; saturates at zero. 'last' flags count==1 so the
// owner can register a pulse that lines up with the zero cycle.
module dec_hold_timer
  import dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);
  logic [CNT_W-1:0] cnt;

  // load has priority over decrement; never wraps below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= CNT_RST;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/dec2_4_timed.sv
// Sequential 2-to-4 decoder: accepts {I1,I0} via valid/ready and holds the
// one-hot output for HOLD_CYCLES cycles. Define DEC_GAP_EN to compile in the
// GAP state (forced all-zero GAP_CYCLES after each hold, break-before-make).
module dec2_4_timed
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid_i,
  input  logic I1,
  input  logic I0,
  output logic ready_o,
  output logic O3,
  output logic O2,
  output logic O1,
  output logic O0,
  output logic done_o
);
`ifdef DEC_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic             HOLD_ONE  = (HOLD_CYCLES == 1);

  dec_state_e state;
  logic [3:0] o_q;
  logic       done_q;
  logic       hold_zero, hold_last, gap_zero;
  logic       accept;
  logic [1:0] code;

  assign code    = {I1, I0};
  assign ready_o = en & ((state == IDLE) |
                         ((state == DRIVE) & hold_zero & !GAP_EN));
  assign accept  = valid_i & ready_o;

  // Hold timer: reloaded on every accept, cleared while disabled
  dec_hold_timer u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept | !en),
    .load_val (en ? HOLD_LOAD : CNT_RST),
    .dec      (state == DRIVE),
    .zero     (hold_zero),
    .last     (hold_last)
  );

`ifdef DEC_GAP_EN
  logic gap_last_unused;

  // Gap timer: armed on the last DRIVE cycle, cleared while disabled
  dec_hold_timer u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (((state == DRIVE) & hold_zero) | !en),
    .load_val (en ? GAP_LOAD : CNT_RST),
    .dec      (state == GAP),
    .zero     (gap_zero),
    .last     (gap_last_unused)
  );
`else
  logic unused_gap;
  assign unused_gap = ^GAP_LOAD;
  assign gap_zero   = 1'b1;
`endif

  // Control FSM with registered one-hot outputs and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STATE_RST;
      o_q    <= OUT_RST;
      done_q <= DONE_RST;
    end else if (!en) begin
      state  <= IDLE;
      o_q    <= OUT_RST;
      done_q <= DONE_RST;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state  <= DRIVE;
          o_q    <= onehot4(code);
          done_q <= HOLD_ONE;
        end
        DRIVE: begin
          if (!hold_zero) begin
            done_q <= hold_last;
          end else if (GAP_EN) begin
            state  <= GAP;
            o_q    <= OUT_RST;
            done_q <= DONE_RST;
          end else if (accept) begin
            o_q    <= onehot4(code);
            done_q <= HOLD_ONE;
          end else begin
            state  <= IDLE;
            o_q    <= OUT_RST;
            done_q <= DONE_RST;
          end
        end
        GAP: if (gap_zero) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign {O3, O2, O1, O0} = o_q;
  assign done_o           = done_q;
endmodule

// File: tb/tb_dec2_4_timed.sv
// Directed table-driven bench for dec2_4_timed. Four instances with
// different hold lengths share clock and reset; each table row drives one
// instance for one cycle and checks its outputs and ready in that cycle.
module tb_dec2_4_timed;
`ifdef DEC_GAP_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0]       en_s, vld_s, dn_s, rdy_s;
  logic [3:0][1:0]  code_s;
  logic [3:0][3:0]  o_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dec2_4_timed #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en_s[0]), .valid_i(vld_s[0]),
    .I1(code_s[0][1]), .I0(code_s[0][0]), .ready_o(rdy_s[0]),
    .O3(o_s[0][3]), .O2(o_s[0][2]), .O1(o_s[0][1]), .O0(o_s[0][0]),
    .done_o(dn_s[0]));
  dec2_4_timed #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en_s[1]), .valid_i(vld_s[1]),
    .I1(code_s[1][1]), .I0(code_s[1][0]), .ready_o(rdy_s[1]),
    .O3(o_s[1][3]), .O2(o_s[1][2]), .O1(o_s[1][1]), .O0(o_s[1][0]),
    .done_o(dn_s[1]));
  dec2_4_timed #(.HOLD_CYCLES(1), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en_s[2]), .valid_i(vld_s[2]),
    .I1(code_s[2][1]), .I0(code_s[2][0]), .ready_o(rdy_s[2]),
    .O3(o_s[2][3]), .O2(o_s[2][2]), .O1(o_s[2][1]), .O0(o_s[2][0]),
    .done_o(dn_s[2]));
  dec2_4_timed #(.HOLD_CYCLES(2), .GAP_CYCLES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en_s[3]), .valid_i(vld_s[3]),
    .I1(code_s[3][1]), .I0(code_s[3][0]), .ready_o(rdy_s[3]),
    .O3(o_s[3][3]), .O2(o_s[3][2]), .O1(o_s[3][1]), .O0(o_s[3][0]),
    .done_o(dn_s[3]));

  typedef struct {
    int         u;
    logic       en;
    logic       vld;
    logic [1:0] code;
    logic [3:0] o;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int u, logic e, logic v, logic [1:0] c,
                              logic [3:0] o, logic dn, logic rdy);
    vec_t r;
    r.u = u; r.en = e; r.vld = v; r.code = c; r.o = o; r.dn = dn; r.rdy = rdy;
    tbl.push_back(r);
  endfunction

  task automatic chk(string nm, int idx, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en_s   = 4'b1111;
    vld_s  = 4'b0000;
    code_s = '0;

    // u0, HOLD 4: code 10 -> O2 for 4 cycles, done in the 4th
    add(0, 1, 1, 2'b10, 4'b0000, 0, 1);
    add(0, 1, 0, 2'b10, 4'b0100, 0, 0);
    add(0, 1, 0, 2'b10, 4'b0100, 0, 0);
    add(0, 1, 0, 2'b10, 4'b0100, 0, 0);
    add(0, 1, 0, 2'b10, 4'b0100, 1, !G);
    add(0, 1, 0, 2'b10, 4'b0000, 0, !G);
    add(0, 1, 0, 2'b10, 4'b0000, 0, !G);
    add(0, 1, 0, 2'b10, 4'b0000, 0, 1);
    // u0: en dropped in the 2nd hold cycle aborts with no done pulse
    add(0, 1, 1, 2'b01, 4'b0000, 0, 1);
    add(0, 1, 0, 2'b01, 4'b0010, 0, 0);
    add(0, 0, 1, 2'b01, 4'b0010, 0, 0);
    add(0, 0, 1, 2'b01, 4'b0000, 0, 0);
    add(0, 0, 0, 2'b01, 4'b0000, 0, 0);
    add(0, 1, 0, 2'b01, 4'b0000, 0, 1);
`ifndef DEC_GAP_EN
    // u1, HOLD 3: 01 then 11 offered continuously, no zero cycle between
    add(1, 1, 1, 2'b01, 4'b0000, 0, 1);
    add(1, 1, 1, 2'b11, 4'b0010, 0, 0);
    add(1, 1, 1, 2'b11, 4'b0010, 0, 0);
    add(1, 1, 1, 2'b11, 4'b0010, 1, 1);
    add(1, 1, 0, 2'b11, 4'b1000, 0, 0);
    add(1, 1, 0, 2'b11, 4'b1000, 0, 0);
    add(1, 1, 0, 2'b11, 4'b1000, 1, 1);
    add(1, 1, 0, 2'b11, 4'b0000, 0, 1);
    // u2, HOLD 1: one code per cycle, done every cycle
    add(2, 1, 1, 2'b00, 4'b0000, 0, 1);
    add(2, 1, 1, 2'b01, 4'b0001, 1, 1);
    add(2, 1, 1, 2'b10, 4'b0010, 1, 1);
    add(2, 1, 1, 2'b11, 4'b0100, 1, 1);
    add(2, 1, 0, 2'b11, 4'b1000, 1, 1);
    add(2, 1, 0, 2'b11, 4'b0000, 0, 1);
    // u3, HOLD 2: same code twice gives a continuous 4-cycle high
    add(3, 1, 1, 2'b00, 4'b0000, 0, 1);
    add(3, 1, 1, 2'b00, 4'b0001, 0, 0);
    add(3, 1, 1, 2'b00, 4'b0001, 1, 1);
    add(3, 1, 0, 2'b00, 4'b0001, 0, 0);
    add(3, 1, 0, 2'b00, 4'b0001, 1, 1);
    add(3, 1, 0, 2'b00, 4'b0000, 0, 1);
`else
    // u3, HOLD 2 GAP 2: 00 offered continuously -> gap, one idle, rehold
    add(3, 1, 1, 2'b00, 4'b0000, 0, 1);
    add(3, 1, 1, 2'b00, 4'b0001, 0, 0);
    add(3, 1, 1, 2'b00, 4'b0001, 1, 0);
    add(3, 1, 1, 2'b00, 4'b0000, 0, 0);
    add(3, 1, 1, 2'b00, 4'b0000, 0, 0);
    add(3, 1, 1, 2'b00, 4'b0000, 0, 1);
    add(3, 1, 0, 2'b00, 4'b0001, 0, 0);
    add(3, 1, 0, 2'b00, 4'b0001, 1, 0);
    add(3, 1, 0, 2'b00, 4'b0000, 0, 0);
    add(3, 1, 0, 2'b00, 4'b0000, 0, 0);
    add(3, 1, 0, 2'b00, 4'b0000, 0, 1);
`endif

    // reset state: outputs clear, ready follows en
    #1;
    chk("rst_o",     0, o_s[0] | o_s[1] | o_s[2] | o_s[3], 4'b0000);
    chk("rst_done",  0, {dn_s}, 4'b0000);
    chk("rst_ready", 0, {rdy_s}, 4'b1111);
    #2 rst_n = 1'b1;

    @(negedge clk);
    foreach (tbl[i]) begin
      en_s[tbl[i].u]   = tbl[i].en;
      vld_s[tbl[i].u]  = tbl[i].vld;
      code_s[tbl[i].u] = tbl[i].code;
      #1;
      chk("out",   i, o_s[tbl[i].u], tbl[i].o);
      chk("done",  i, {3'b0, dn_s[tbl[i].u]}, {3'b0, tbl[i].dn});
      chk("ready", i, {3'b0, rdy_s[tbl[i].u]}, {3'b0, tbl[i].rdy});
      @(negedge clk);
    end

    // async reset mid-hold on u0, then immediate accept after release
    en_s[0] = 1'b1; vld_s[0] = 1'b1; code_s[0] = 2'b11;
    @(negedge clk);
    vld_s[0] = 1'b0;
    #1;
    chk("pre_rst_o", 0, o_s[0], 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o",     0, o_s[0], 4'b0000);
    chk("arst_done",  0, {3'b0, dn_s[0]}, 4'b0000);
    chk("arst_ready", 0, {3'b0, rdy_s[0]}, 4'b0001);
    @(negedge clk);
    #2 rst_n = 1'b1;
    vld_s[0] = 1'b1; code_s[0] = 2'b11;
    @(negedge clk);
    vld_s[0] = 1'b0;
    #1;
    chk("post_rst_o",    0, o_s[0], 4'b1000);
    chk("post_rst_done", 0, {3'b0, dn_s[0]}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
